// File: rtl/msrv32_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_rf_write_scheduler
// Description : Arbitrates the single register-file write port between the
//               stage-3 writeback (fixed priority) and one long-latency unit
//               (valid/ready). Tracks registers awaiting long-latency results
//               in a busy scoreboard, raises stage-2 RAW/WAW hazard stalls,
//               and asserts a writeback hold when the unit is starved.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   1   system clock, rising edge
//   reset_in         in   1   asynchronous active-low reset
//   wb_wr_en_in      in   1   stage-3 write request
//   wb_rd_addr_in    in   5   stage-3 destination
//   wb_rd_in         in  32   stage-3 write data
//   dec_rs_1_addr_in in   5   stage-2 source 1
//   dec_rs_2_addr_in in   5   stage-2 source 2
//   dec_rd_addr_in   in   5   stage-2 destination
//   dec_wr_en_in     in   1   stage-2 instruction writes dec_rd_addr_in
//   lu_issue_in      in   1   stage-2 issues a long-latency op
//   lu_valid_in      in   1   long-latency result valid
//   lu_rd_addr_in    in   5   result destination
//   lu_data_in       in  32   result data
//   lu_ready_out     out  1   result accepted this cycle
//   hazard_stall_out out  1   stage 2 must hold its instruction
//   wb_hold_out      out  1   stage 3 must present no write
//   rf_wr_en_out     out  1   register file write enable
//   rf_rd_addr_out   out  5   register file write address
//   rf_rd_out        out 32   register file write data
//   busy_vec_out     out 32   scoreboard (bit 0 always 0)
// ============================================================================
module msrv32_rf_write_scheduler #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        wb_wr_en_in,
  input  logic [4:0]  wb_rd_addr_in,
  input  logic [31:0] wb_rd_in,
  input  logic [4:0]  dec_rs_1_addr_in,
  input  logic [4:0]  dec_rs_2_addr_in,
  input  logic [4:0]  dec_rd_addr_in,
  input  logic        dec_wr_en_in,
  input  logic        lu_issue_in,
  input  logic        lu_valid_in,
  input  logic [4:0]  lu_rd_addr_in,
  input  logic [31:0] lu_data_in,
  output logic        lu_ready_out,
  output logic        hazard_stall_out,
  output logic        wb_hold_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_rd_out,
  output logic [31:0] busy_vec_out
);

  localparam int unsigned c_cnt_w = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [31:0]          r_busy;
  logic [31:0]          w_busy_nxt;

  logic w_wb_act;
  logic w_ready;
  logic w_xfer;
  logic w_blocked;
  logic w_stall;
  logic w_set;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rd;

  // A pending register stops being a hazard in the cycle its result is being
  // written, because the register file forwards that write to its readers.
  function automatic logic f_hit(input logic [31:0] busy, input logic xfer,
                                 input logic [4:0] lu_rd, input logic [4:0] a);
    return busy[a] & ~(xfer & (lu_rd == a));
  endfunction

  // All combinational handshakes are forced quiet while reset is held so
  // nothing upstream or in the file acts on a half-reset scheduler.
  assign w_wb_act  = wb_wr_en_in & (wb_rd_addr_in != 5'd0);
  assign w_ready   = reset_in & ~w_wb_act;
  assign w_xfer    = lu_valid_in & w_ready;
  assign w_blocked = lu_valid_in & ~w_xfer;

  assign w_hit_rs1 = f_hit(r_busy, w_xfer, lu_rd_addr_in, dec_rs_1_addr_in);
  assign w_hit_rs2 = f_hit(r_busy, w_xfer, lu_rd_addr_in, dec_rs_2_addr_in);
  assign w_hit_rd  = f_hit(r_busy, w_xfer, lu_rd_addr_in, dec_rd_addr_in);
  assign w_stall   = reset_in & (w_hit_rs1 | w_hit_rs2 | (dec_wr_en_in & w_hit_rd));

  // A stalled instruction has not really issued, so it must not mark busy.
  assign w_set = lu_issue_in & (dec_rd_addr_in != 5'd0) & ~w_stall;

  // --------------------------------------------------------------------------
  // Write-port mux
  // --------------------------------------------------------------------------
  always_comb begin
    rf_wr_en_out   = 1'b0;
    rf_rd_addr_out = 5'd0;
    rf_rd_out      = 32'd0;
    if (reset_in) begin
      if (w_wb_act) begin
        rf_wr_en_out   = 1'b1;
        rf_rd_addr_out = wb_rd_addr_in;
        rf_rd_out      = wb_rd_in;
      end else if (w_xfer) begin
        rf_wr_en_out   = (lu_rd_addr_in != 5'd0);
        rf_rd_addr_out = lu_rd_addr_in;
        rf_rd_out      = lu_data_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard: set is applied after clear so an issue to the register being
  // retired in the same cycle leaves it pending for the new producer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) begin
      w_busy_nxt[lu_rd_addr_in] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[dec_rd_addr_in] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_blocked) begin
          if (MAX_WAIT == 1) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_WAIT;
          end
          w_cnt_nxt = c_cnt_w'(1);
        end
      end
      S_WAIT: begin
        if (!w_blocked) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_w'(MAX_WAIT - 1)) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // A writeback arriving during hold still wins the port; the hold
        // simply persists until the unit gets through or withdraws.
        if (!w_blocked) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign lu_ready_out     = w_ready;
  assign hazard_stall_out = w_stall;
  assign wb_hold_out      = (r_state == S_HOLD);
  assign busy_vec_out     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_rf_write_scheduler
// Description : Self-checking bench for msrv32_rf_write_scheduler. Stimulus
//               pushes expected outputs from a behavioural model into a queue;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_rf_write_scheduler;

  localparam int unsigned c_max_wait = 4;

  typedef struct {
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dec_rd;
    logic        dec_wr_en;
    logic        issue;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
  } stim_t;

  typedef struct {
    logic        rst;
    logic        xfer;
    logic        ready;
    logic        stall;
    logic        hold;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        wb_wr_en_in;
  logic [4:0]  wb_rd_addr_in;
  logic [31:0] wb_rd_in;
  logic [4:0]  dec_rs_1_addr_in;
  logic [4:0]  dec_rs_2_addr_in;
  logic [4:0]  dec_rd_addr_in;
  logic        dec_wr_en_in;
  logic        lu_issue_in;
  logic        lu_valid_in;
  logic [4:0]  lu_rd_addr_in;
  logic [31:0] lu_data_in;
  logic        lu_ready_out;
  logic        hazard_stall_out;
  logic        wb_hold_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_rd_out;
  logic [31:0] busy_vec_out;

  msrv32_rf_write_scheduler #(.MAX_WAIT(c_max_wait)) dut (
    .clock            (clk),
    .reset_in         (reset_in),
    .wb_wr_en_in      (wb_wr_en_in),
    .wb_rd_addr_in    (wb_rd_addr_in),
    .wb_rd_in         (wb_rd_in),
    .dec_rs_1_addr_in (dec_rs_1_addr_in),
    .dec_rs_2_addr_in (dec_rs_2_addr_in),
    .dec_rd_addr_in   (dec_rd_addr_in),
    .dec_wr_en_in     (dec_wr_en_in),
    .lu_issue_in      (lu_issue_in),
    .lu_valid_in      (lu_valid_in),
    .lu_rd_addr_in    (lu_rd_addr_in),
    .lu_data_in       (lu_data_in),
    .lu_ready_out     (lu_ready_out),
    .hazard_stall_out (hazard_stall_out),
    .wb_hold_out      (wb_hold_out),
    .rf_wr_en_out     (rf_wr_en_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_rd_out        (rf_rd_out),
    .busy_vec_out     (busy_vec_out)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference state: which registers are pending, and how many consecutive
  // cycles the unit has been refused.
  bit   m_busy [32];
  int   m_run;

  stim_t cur;
  exp_t  cur_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.wb_en = 1'b0; s.wb_rd = 5'd0; s.wb_data = 32'd0;
    s.rs1 = 5'd0; s.rs2 = 5'd0; s.dec_rd = 5'd0; s.dec_wr_en = 1'b0;
    s.issue = 1'b0; s.lu_valid = 1'b0; s.lu_rd = 5'd0; s.lu_data = 32'd0;
    return s;
  endfunction

  function automatic bit pend(input int a, input bit xfer, input int lu_rd);
    return m_busy[a] && !(xfer && lu_rd == a);
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit   wb_act;
    e.rst = s.rst; e.xfer = 0; e.ready = 0; e.stall = 0; e.hold = 0;
    e.wr_en = 0; e.addr = 5'd0; e.data = 32'd0; e.busy = 32'd0;
    if (s.rst) begin
      wb_act  = s.wb_en && (s.wb_rd != 0);
      e.ready = !wb_act;
      e.xfer  = s.lu_valid && e.ready;
      if (wb_act) begin
        e.wr_en = 1; e.addr = s.wb_rd; e.data = s.wb_data;
      end else if (e.xfer) begin
        e.wr_en = (s.lu_rd != 0); e.addr = s.lu_rd; e.data = s.lu_data;
      end
      e.stall = pend(int'(s.rs1), e.xfer, int'(s.lu_rd)) ||
                pend(int'(s.rs2), e.xfer, int'(s.lu_rd)) ||
                (s.dec_wr_en && pend(int'(s.dec_rd), e.xfer, int'(s.lu_rd)));
      e.hold  = (m_run >= int'(c_max_wait));
      for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
    end
    return e;
  endfunction

  task automatic model_edge(input stim_t s, input exp_t e);
    if (s.rst) begin
      if (e.xfer) m_busy[s.lu_rd] = 0;
      if (s.issue && !e.stall && s.dec_rd != 0) m_busy[s.dec_rd] = 1;
      m_busy[0] = 0;
      m_run = (s.lu_valid && !e.xfer) ? m_run + 1 : 0;
    end
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    model_edge(cur, cur_e);
    #1;
    reset_in         = s.rst;
    wb_wr_en_in      = s.wb_en;
    wb_rd_addr_in    = s.wb_rd;
    wb_rd_in         = s.wb_data;
    dec_rs_1_addr_in = s.rs1;
    dec_rs_2_addr_in = s.rs2;
    dec_rd_addr_in   = s.dec_rd;
    dec_wr_en_in     = s.dec_wr_en;
    lu_issue_in      = s.issue;
    lu_valid_in      = s.lu_valid;
    lu_rd_addr_in    = s.lu_rd;
    lu_data_in       = s.lu_data;
    if (!s.rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_run = 0;
    end
    cur   = s;
    cur_e = model_out(s);
    exp_q.push_back(cur_e);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lu_ready", {31'd0, lu_ready_out}, {31'd0, e.ready});
      chk("stall", {31'd0, hazard_stall_out}, {31'd0, e.stall});
      chk("wb_hold", {31'd0, wb_hold_out}, {31'd0, e.hold});
      chk("rf_wr_en", {31'd0, rf_wr_en_out}, {31'd0, e.wr_en});
      chk("busy_vec", busy_vec_out, e.busy);
      if (e.rst && e.wr_en) begin
        chk("rf_addr", {27'd0, rf_rd_addr_out}, {27'd0, e.addr});
        chk("rf_data", rf_rd_out, e.data);
      end
    end
  end

  initial begin
    stim_t s;
    bit    keep;
    reset_in = 1'b0; wb_wr_en_in = 1'b0; wb_rd_addr_in = 5'd0; wb_rd_in = 32'd0;
    dec_rs_1_addr_in = 5'd0; dec_rs_2_addr_in = 5'd0; dec_rd_addr_in = 5'd0;
    dec_wr_en_in = 1'b0; lu_issue_in = 1'b0; lu_valid_in = 1'b0;
    lu_rd_addr_in = 5'd0; lu_data_in = 32'd0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_run = 0;
    cur = idle(); cur.rst = 1'b0;
    cur_e = model_out(cur);

    s = idle(); s.rst = 1'b0; apply(s); apply(s);
    s = idle(); apply(s);

    // Collision: writeback wins, the unit goes through the next cycle.
    s = idle(); s.wb_en = 1; s.wb_rd = 5; s.wb_data = 32'h11;
    s.lu_valid = 1; s.lu_rd = 7; s.lu_data = 32'h22; apply(s);
    s.wb_en = 0; apply(s);
    s = idle(); apply(s);

    // Scoreboard: issue, RAW stall, forwarded retire, same-edge set/clear.
    s = idle(); s.issue = 1; s.dec_wr_en = 1; s.dec_rd = 9; apply(s);
    s = idle(); s.rs1 = 9; apply(s);
    s.lu_valid = 1; s.lu_rd = 9; s.lu_data = 32'h99; apply(s);
    s = idle(); apply(s);
    s = idle(); s.issue = 1; s.dec_wr_en = 1; s.dec_rd = 9;
    s.lu_valid = 1; s.lu_rd = 9; s.lu_data = 32'h98; apply(s);
    s = idle(); s.rs2 = 9; apply(s);
    s = idle(); s.lu_valid = 1; s.lu_rd = 9; s.lu_data = 32'h97; apply(s);
    s = idle(); apply(s);

    // Starvation: writeback every cycle while the unit waits.
    s = idle(); s.wb_en = 1; s.wb_rd = 1; s.lu_valid = 1; s.lu_rd = 4; s.lu_data = 32'h44;
    for (int i = 0; i < 6; i++) begin s.wb_data = 32'h100 + i; apply(s); end
    s.wb_en = 0; apply(s);
    s = idle(); apply(s);

    // x0: never busy, and a writeback to x0 does not block the unit.
    s = idle(); s.issue = 1; s.dec_wr_en = 1; s.dec_rd = 0; apply(s);
    s = idle(); s.wb_en = 1; s.wb_rd = 0; s.wb_data = 32'hdead;
    s.lu_valid = 1; s.lu_rd = 6; s.lu_data = 32'h66; apply(s);
    s = idle(); apply(s);

    // WAW: a stalled issue must not mark its destination.
    s = idle(); s.issue = 1; s.dec_wr_en = 1; s.dec_rd = 3; apply(s);
    s = idle(); s.dec_wr_en = 1; s.dec_rd = 3; apply(s);
    s.issue = 1; apply(s);
    s = idle(); s.rs1 = 3; s.issue = 1; s.dec_rd = 11; apply(s);
    s = idle(); s.lu_valid = 1; s.lu_rd = 3; s.lu_data = 32'h33; apply(s);
    s = idle(); apply(s);

    // Reset asserted mid-hold with scoreboard entries outstanding.
    s = idle(); s.issue = 1; s.dec_rd = 12; apply(s);
    s = idle(); s.wb_en = 1; s.wb_rd = 2; s.lu_valid = 1; s.lu_rd = 13; s.lu_data = 32'h55;
    for (int i = 0; i < 5; i++) apply(s);
    s.rst = 0; apply(s);
    s = idle(); apply(s); apply(s);

    // Randomised traffic honouring the unit's hold-until-accepted protocol.
    for (int n = 0; n < 3000; n++) begin
      keep = cur.rst && cur.lu_valid && !cur_e.xfer;
      s = idle();
      s.rst       = ($urandom_range(0, 249) != 0);
      s.wb_en     = (m_run >= int'(c_max_wait)) ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1) == 1;
      s.wb_rd     = 5'($urandom_range(0, 7));
      s.wb_data   = $urandom;
      s.rs1       = 5'($urandom_range(0, 15));
      s.rs2       = 5'($urandom_range(0, 15));
      s.dec_rd    = 5'($urandom_range(0, 15));
      s.dec_wr_en = $urandom_range(0, 1) == 1;
      s.issue     = ($urandom_range(0, 2) == 0);
      if (keep) begin
        s.lu_valid = 1; s.lu_rd = cur.lu_rd; s.lu_data = cur.lu_data;
      end else begin
        s.lu_valid = ($urandom_range(0, 2) == 0);
        s.lu_rd    = 5'($urandom_range(0, 15));
        s.lu_data  = $urandom;
      end
      apply(s);
    end

    s = idle(); apply(s);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
